// File: rtl/memcheck.sv
// memcheck: read-back checker for the memory_controller port.
// It reads n consecutive words starting at address m and compares the low byte
// of each word with c[7:0]. When it is done it reports the mismatch count and
// the first failing address, together with a one-cycle finish pulse.
// The block only reads. Each read takes 3 cycles (ISSUE, WAIT, CMP), so the
// controller's 2-cycle read path is always met.
module memcheck #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] m,
  input  logic [31:0]       n,
  input  logic [31:0]       c,
  output logic              finish,
  output logic [31:0]       return_val,
  output logic [ADDR_W-1:0] first_bad,
  output logic [ADDR_W-1:0] memory_controller_address,
  output logic              memory_controller_write_enable,
  output logic [DATA_W-1:0] memory_controller_in,
  input  logic [DATA_W-1:0] memory_controller_out
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_CMP   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [ADDR_W-1:0] NONE = '1;

  logic [2:0]        state;
  logic [31:0]       idx, cnt, len;
  logic [ADDR_W-1:0] base, bad_addr;
  logic [7:0]        exp_b;
  logic              accept;

  // A start is accepted in IDLE. It is also accepted in DONE, so that when
  // start is held high the next check begins the cycle after DONE. The
  // finish/return_val/first_bad outputs are still loaded from the finished run
  // on that same edge.
  assign accept = start && (state == S_IDLE || state == S_DONE);

  assign memory_controller_write_enable = 1'b0;
  assign memory_controller_in           = '0;

  // Check sequencer. All outputs are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                     <= S_IDLE;
      idx                       <= '0;
      cnt                       <= '0;
      len                       <= '0;
      base                      <= '0;
      exp_b                     <= '0;
      bad_addr                  <= NONE;
      finish                    <= 1'b0;
      return_val                <= '0;
      first_bad                 <= NONE;
      memory_controller_address <= '0;
    end else begin
      finish <= 1'b0;
      case (state)
        S_IDLE: begin
          // first_bad is cleared only on a start from IDLE. On a start from
          // DONE it must keep the result that finish is reporting.
          if (start) first_bad <= NONE;
        end
        S_SETUP: state <= (len == 32'd0) ? S_DONE : S_ISSUE;
        S_ISSUE: begin
          memory_controller_address <= base + ADDR_W'(idx);
          state                     <= S_WAIT;
        end
        S_WAIT: state <= S_CMP;
        S_CMP: begin
          if (memory_controller_out[7:0] != exp_b) begin
            cnt <= cnt + 32'd1;
            if (cnt == 32'd0) bad_addr <= memory_controller_address;
          end
          if (idx + 32'd1 == len) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + 32'd1;
            state <= S_ISSUE;
          end
        end
        S_DONE: begin
          finish     <= 1'b1;
          return_val <= cnt;
          first_bad  <= bad_addr;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // Latch the arguments. This assignment comes last so that it overrides
      // the DONE -> IDLE transition.
      if (accept) begin
        base     <= m;
        len      <= n;
        exp_b    <= c[7:0];
        cnt      <= '0;
        idx      <= '0;
        bad_addr <= NONE;
        state    <= S_SETUP;
      end
    end
  end

endmodule

// File: tb/tb_memcheck.sv
// Directed bench for memcheck. A small memory model answers reads one
// registered cycle after the address is seen, and that address is held
// through WAIT and CMP.
module tb_memcheck;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] m, n, c;
  logic        finish;
  logic [31:0] return_val, first_bad, mc_addr, mc_in, mc_out;
  logic        mc_we;

  int n_vec = 0;
  int n_bad = 0;

  memcheck #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .m(m), .n(n), .c(c),
    .finish(finish), .return_val(return_val), .first_bad(first_bad),
    .memory_controller_address(mc_addr),
    .memory_controller_write_enable(mc_we),
    .memory_controller_in(mc_in),
    .memory_controller_out(mc_out)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  logic [31:0] rd_q;
  always @(posedge clk) rd_q <= mem[mc_addr[5:0]];
  assign mc_out = rd_q;

  int we_bad = 0, in_bad = 0, addr_bad = 0;
  logic watch_addr = 1'b0;
  always @(negedge clk) begin
    if (mc_we !== 1'b0) we_bad++;
    if (mc_in !== 32'd0) in_bad++;
    if (watch_addr && mc_addr !== 32'd0) addr_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  // Start one check, scramble the inputs after acceptance, and return the
  // latency from the start-sampling edge to finish.
  task automatic run(input logic [31:0] mm, input logic [31:0] nn,
                     input logic [31:0] cc, output int cyc);
    @(negedge clk);
    m = mm; n = nn; c = cc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m = $urandom; n = $urandom; c = $urandom;
    cyc = 0;
    while (cyc < 500 && !finish) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!finish) chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  int cyc, fcnt, f1;
  int fin_at [0:3];
  logic [31:0] rv_at [0:3];

  initial begin
    start = 1'b0; m = '0; n = '0; c = '0; reset = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    #1;
    chk("rst_finish", {31'd0, finish}, 32'd0);
    chk("rst_rv", return_val, 32'd0);
    chk("rst_fb", first_bad, 32'hFFFF_FFFF);
    chk("rst_addr", mc_addr, 32'd0);
    do_reset();

    // Mixed bytes; the upper bits must be ignored.
    mem[4] = 32'hFFFF_FF11; mem[5] = 32'h22; mem[6] = 32'h1234_5611; mem[7] = 32'h33;
    run(32'd4, 32'd4, 32'h0000_0011, cyc);
    chk("mix_rv", return_val, 32'd2);
    chk("mix_fb", first_bad, 32'd5);
    chk("mix_lat", cyc, 32'd14);

    // Reset arrives in the 3rd CMP of an n=8 check.
    for (int i = 0; i < 4; i++) mem[i] = 32'h5A;
    @(negedge clk); m = 0; n = 8; c = 32'h5A; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_finish", {31'd0, finish}, 32'd0);
    chk("mid_rv", return_val, 32'd0);
    chk("mid_fb", first_bad, 32'hFFFF_FFFF);
    chk("mid_addr", mc_addr, 32'd0);
    @(negedge clk) reset = 1'b0;
    fcnt = 0;
    repeat (30) begin @(posedge clk); #1; if (finish) fcnt++; end
    chk("mid_quiet", fcnt, 32'd0);

    // Clean run after the reset.
    run(32'd0, 32'd4, 32'h5A, cyc);
    chk("ok_lat", cyc, 32'd14);
    chk("ok_rv", return_val, 32'd0);
    chk("ok_fb", first_bad, 32'hFFFF_FFFF);

    // Start pulses during a check are ignored.
    @(negedge clk); m = 0; n = 4; c = 32'h5A; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    fcnt = 0; f1 = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk); start = (i == 3 || i == 7 || i == 12);
      @(posedge clk); #1;
      if (finish) begin fcnt++; if (f1 == 0) f1 = i; end
    end
    start = 1'b0;
    chk("pulse_cnt", fcnt, 32'd1);
    chk("pulse_lat", f1, 32'd14);

    // Start held high: back-to-back checks, all locations mismatch c=0.
    @(negedge clk); m = 0; n = 4; c = 32'h0; start = 1'b1;
    fcnt = 0;
    for (int i = 0; i <= 45; i++) begin
      @(posedge clk); #1;
      if (finish && fcnt < 4) begin fin_at[fcnt] = i; rv_at[fcnt] = return_val; fcnt++; end
    end
    @(negedge clk) start = 1'b0;
    repeat (20) @(posedge clk);
    chk("b2b_cnt", fcnt, 32'd3);
    chk("b2b_f0", fin_at[0], 32'd14);
    chk("b2b_f1", fin_at[1], 32'd28);
    chk("b2b_f2", fin_at[2], 32'd42);
    chk("b2b_rv1", rv_at[1], 32'd4);

    // Address wrap: FFFFFFFE, FFFFFFFF, 0, 1.
    mem[62] = 32'h77; mem[63] = 32'h5A;
    run(32'hFFFF_FFFE, 32'd4, 32'h5A, cyc);
    chk("wrap_rv", return_val, 32'd1);
    chk("wrap_fb", first_bad, 32'hFFFF_FFFE);

    // n=0: no reads, finish after 2 cycles.
    do_reset();
    watch_addr = 1'b1;
    run(32'd7, 32'd0, 32'h5A, cyc);
    repeat (3) @(posedge clk);
    watch_addr = 1'b0;
    chk("n0_lat", cyc, 32'd2);
    chk("n0_rv", return_val, 32'd0);
    chk("n0_addr", addr_bad, 32'd0);

    // Image left by memset(m=0, c=0xA5, n=16), then one corrupted word.
    for (int i = 0; i < 16; i++) mem[i] = {24'h00_0000, 8'hA5};
    run(32'd0, 32'd16, 32'hA5, cyc);
    chk("ms_rv", return_val, 32'd0);
    chk("ms_lat", cyc, 32'd50);
    mem[9] = 32'h0000_00A4;
    run(32'd0, 32'd16, 32'hA5, cyc);
    chk("ms_bad_rv", return_val, 32'd1);
    chk("ms_bad_fb", first_bad, 32'd9);

    chk("we_zero", we_bad, 32'd0);
    chk("in_zero", in_bad, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
